vga_burst_reader: RTL
=====================

// Module: vga_burst_reader
// PURPOSE
//  Avalon-MM burst-read host that streams the framebuffer from SDRAM into the VGA pixel FIFO.
//  Walks the frame linearly from BASE_ADDR in fixed bursts, issuing a burst only when the FIFO has room.
//  Sits between the VGA pixel FIFO (write side) and the SDRAM arbiter's VGA agent port.
//  Restarts on every frame_start; discards data from bursts still in flight across a restart.
// PARAMETERS
//  HDISP       800     active pixels per line
//  VDISP       480     active lines per frame
//  BURST       16      words per burst, power of 2, HDISP*VDISP % BURST == 0
//  BASE_ADDR   32'h0   byte address of pixel (0,0), 4-byte aligned
//  FIFO_DEPTH  256     pixel FIFO depth in words, >= 2*BURST
// PORTS
//  clk            in   1                         system clock
//  rst            in   1                         async reset, active high
//  frame_start    in   1                         1-cycle pulse: (re)start at BASE_ADDR
//  fifo_level     in   $clog2(FIFO_DEPTH)+1      words currently stored in pixel FIFO
//  av_address     out  32                        byte address of burst
//  av_read        out  1                         read request
//  av_burstcount  out  $clog2(BURST)+1           constant BURST
//  av_byteenable  out  4                         constant 4'hF
//  av_waitrequest in   1                         agent stall
//  av_readdata    in   32                        read data
//  av_readdatavalid in 1                         read data valid
//  pix_data       out  32                        pixel word to FIFO
//  pix_wr         out  1                         FIFO write strobe
// BEHAVIOUR
//  Reset: FSM=IDLE, av_read=0, av_address=BASE_ADDR, inflight=0, word_idx=0, discard=0, pix_wr=0.
//  FSM states: IDLE, CHECK, REQ, RESTART.
//   IDLE: av_read=0; frame_start -> CHECK, av_address<=BASE_ADDR, word_idx<=0.
//   CHECK: free = FIFO_DEPTH - fifo_level - inflight; free >= BURST -> REQ else stay.
//   REQ: av_read=1, address/burstcount held stable while av_waitrequest=1 (Avalon rule).
//     Accept (av_read & !av_waitrequest): inflight += BURST, av_address += 4*BURST,
//     word_idx += BURST; if new word_idx == HDISP*VDISP -> IDLE else CHECK.
//   RESTART: entered from REQ on accept when a restart is pending, or directly from
//     CHECK/IDLE on frame_start; sets discard <= inflight (incl. just-accepted burst),
//     inflight <= 0, av_address <= BASE_ADDR, word_idx <= 0 -> CHECK next cycle.
//  frame_start during REQ with waitrequest high: never drop av_read; latch restart_pend,
//   go RESTART after accept. frame_start in CHECK/IDLE: RESTART next cycle.
//  Read data: each av_readdatavalid: if discard>0 -> discard-=1, pix_wr=0;
//   else pix_wr=1, pix_data=av_readdata, inflight-=1 (registered, 1-cycle latency).
//  Same-cycle accept + readdatavalid: inflight += BURST-1 (never double-count).
//  inflight width $clog2(FIFO_DEPTH)+1; credit rule guarantees inflight+fifo_level <= FIFO_DEPTH,
//   so FIFO never overflows; no underflow/overflow of counters is legal.
//  At most one burst issued per CHECK->REQ pass; min 2 cycles between accepts.
//  End of frame: last word address = BASE_ADDR + 4*(HDISP*VDISP-1); no wrap, waits in IDLE.
//  av_burstcount=BURST, av_byteenable=4'hF whenever av_read=1 (held constant always).
//  rst mid-burst: all state cleared immediately; in-flight data after reset is ignored (discard=0,
//   FSM IDLE => pix_wr forced 0 until first frame_start).
// TESTING
//  1 reset, frame_start, fifo_level=0, waitreq=0 -> first av_read at BASE_ADDR, burstcount=16,
//    second at BASE_ADDR+64; FIFO_DEPTH=256 -> 16 bursts issued before any data returns.
//  2 fifo_level=250 held -> no av_read; drop to 240 -> one burst issued, then stall again.
//  3 waitrequest=1 for 5 cycles during REQ -> av_read/address stable all 5 cycles, accepted on 6th.
//  4 full frame HDISP=8 VDISP=4 BURST=16 -> exactly 2 bursts, addresses 0x0,0x40, then IDLE;
//    32 pix_wr pulses with data in order.
//  5 frame_start with 2 bursts in flight -> 32 readdatavalid beats produce no pix_wr; next
//    burst address = BASE_ADDR; following data written.
//  6 accept coincident with readdatavalid -> inflight increments by 15; rst mid-burst -> av_read=0,
//    pix_wr=0 next cycle, no read until frame_start.

Source files
------------

// File: rtl/vga_burst_reader.sv
// Avalon-MM burst-read host: streams the framebuffer from SDRAM into the VGA pixel FIFO,
// issuing a burst only when the FIFO has credit for it and dropping stale data across restarts.
module vga_burst_reader #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          BURST      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 av_address,
  output logic                        av_read,
  output logic [$clog2(BURST):0]      av_burstcount,
  output logic [3:0]                  av_byteenable,
  input  logic                        av_waitrequest,
  input  logic [31:0]                 av_readdata,
  input  logic                        av_readdatavalid,
  output logic [31:0]                 pix_data,
  output logic                        pix_wr
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = LW + 1;
  localparam int BW    = $clog2(BURST) + 1;
  localparam int IW    = $clog2(TOTAL + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] REQ     = 2'd2;
  localparam logic [1:0] RESTART = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] discard_q, discard_d;
  logic          pend_q, pend_d;
  logic [31:0]   pix_data_q, pix_data_d;
  logic          pix_wr_q, pix_wr_d;

  logic accept;
  logic credit_ok;
  logic beat_kept;
  logic restart_drop;
  logic last_burst;

  assign accept     = (state_q == REQ) && !av_waitrequest;
  assign credit_ok  = (32'(fifo_level) + 32'(inflight_q) + 32'(BURST)) <= 32'(FIFO_DEPTH);
  assign last_burst = (idx_q + IW'(BURST)) == IW'(TOTAL);

  // Discard may hold the previous restart's leftovers plus a full FIFO of credit, hence one extra bit.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    discard_d    = discard_q;
    pend_d       = pend_q;
    pix_data_d   = pix_data_q;
    pix_wr_d     = 1'b0;
    beat_kept    = 1'b0;
    restart_drop = av_readdatavalid && ((discard_q != '0) || (inflight_q != '0));

    if (av_readdatavalid && (state_q != RESTART)) begin
      if (discard_q != '0) begin
        discard_d = discard_q - DW'(1);
      end else if (inflight_q != '0) begin
        beat_kept  = 1'b1;
        pix_wr_d   = 1'b1;
        pix_data_d = av_readdata;
      end
    end

    inflight_d = inflight_q + (accept ? LW'(BURST) : '0) - LW'(beat_kept);

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          addr_d  = BASE_ADDR;
          idx_d   = '0;
          state_d = (inflight_q != '0) ? RESTART : CHECK;
        end
      end
      CHECK: begin
        if (frame_start) begin
          state_d = RESTART;
        end else if (credit_ok) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // av_read is never withdrawn while stalled; a restart waits for the accept.
        if (accept) begin
          addr_d = addr_q + 32'(4 * BURST);
          idx_d  = idx_q + IW'(BURST);
          pend_d = 1'b0;
          if (pend_q || frame_start) begin
            state_d = RESTART;
          end else if (last_burst) begin
            state_d = IDLE;
          end else begin
            state_d = CHECK;
          end
        end else if (frame_start) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        discard_d  = discard_q + DW'(inflight_q) - DW'(restart_drop);
        inflight_d = '0;
        addr_d     = BASE_ADDR;
        idx_d      = '0;
        state_d    = CHECK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      idx_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      pend_q     <= 1'b0;
      pix_data_q <= '0;
      pix_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      pend_q     <= pend_d;
      pix_data_q <= pix_data_d;
      pix_wr_q   <= pix_wr_d;
    end
  end

  assign av_read       = (state_q == REQ);
  assign av_address    = addr_q;
  assign av_burstcount = BW'(BURST);
  assign av_byteenable = 4'hF;
  assign pix_data      = pix_data_q;
  assign pix_wr        = pix_wr_q;

endmodule
